// File: rtl/stdp_weight_updater.sv
// Queues STDP spike events and read-modify-writes one synapse weight per event (step = A >> dt, clamped).
// Latency: push into an idle empty queue -> syn_r_en 2 cycles later, syn_w_en 4 cycles later; one write per 3 cycles.
// Backpressure: evt_ready = !full; kill flushes the queue, drops the in-flight event and suppresses its write. Option: STDP_STATS_EN.
module stdp_weight_updater #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] A_PLUS     = 8'd16,
    parameter logic [7:0] A_MINUS    = 8'd16,
    parameter logic [7:0] W_MAX      = 8'd255,
    parameter logic [7:0] W_MIN      = 8'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kill,
    input  logic        evt_valid,
    output logic        evt_ready,
    input  logic [7:0]  evt_neuron,
    input  logic        evt_type,
    input  logic [3:0]  evt_dt,
    output logic        syn_r_en,
    output logic        syn_w_en,
    output logic [7:0]  syn_neuron_num,
    input  logic [7:0]  syn_rd_weight,
    output logic [7:0]  syn_wr_weight,
    output logic        busy
`ifdef STDP_STATS_EN
    ,
    output logic [15:0] ltp_cnt,
    output logic [15:0] ltd_cnt,
    output logic [15:0] sat_cnt
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {IDLE, RD, CALC, WR} state_t;

    typedef struct packed {
        logic [7:0] neuron;
        logic       ltp;
        logic [3:0] dt;
    } evt_t;

    evt_t             fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    state_t           state_q, state_d;
    evt_t             cur_q, cur_d;
    logic [7:0]       new_w_q, new_w_d;
    logic             sat_q, sat_d;

    logic             push, pop, q_empty, wr_fire;
    evt_t             push_dat;
    logic [7:0]       step;
    logic [8:0]       sum;
    logic signed [9:0] diff;
    logic [7:0]       calc_w;
    logic             calc_sat;

    assign q_empty   = (count_q == '0);
    assign evt_ready = (count_q != DEPTH_C);
    assign push      = evt_valid && evt_ready && !kill;
    assign pop       = !kill && !q_empty && (state_q == IDLE || state_q == WR);
    assign push_dat  = '{neuron: evt_neuron, ltp: evt_type, dt: evt_dt};
    // A write is only real if kill is not cancelling it in the same cycle.
    assign wr_fire   = (state_q == WR) && !kill;

    assign syn_r_en       = (state_q == RD);
    assign syn_w_en       = wr_fire;
    assign syn_neuron_num = (state_q != IDLE) ? cur_q.neuron : 8'd0;
    assign syn_wr_weight  = (state_q == WR) ? new_w_q : 8'd0;
    assign busy           = (state_q != IDLE) || !q_empty;

    // Weight update: shifted step, 9-bit add with upper clamp or signed subtract with lower clamp.
    always_comb begin
        step     = (cur_q.ltp ? A_PLUS : A_MINUS) >> cur_q.dt;
        sum      = {1'b0, syn_rd_weight} + {1'b0, step};
        diff     = $signed({2'b00, syn_rd_weight}) - $signed({2'b00, step});
        calc_w   = 8'd0;
        calc_sat = 1'b0;
        if (cur_q.ltp) begin
            if (sum > {1'b0, W_MAX}) begin
                calc_w   = W_MAX;
                calc_sat = 1'b1;
            end else begin
                calc_w   = sum[7:0];
            end
        end else begin
            if (diff < $signed({2'b00, W_MIN})) begin
                calc_w   = W_MIN;
                calc_sat = 1'b1;
            end else begin
                calc_w   = diff[7:0];
            end
        end
    end

    // Next-state for queue pointers/count and the read-modify-write sequencer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        cur_d    = cur_q;
        new_w_d  = new_w_q;
        sat_d    = sat_q;
        if (kill) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = IDLE;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                cur_d    = fifo_mem_q[rd_ptr_q];
            end
            if (push && !pop)      count_d = count_q + CNT_ONE;
            else if (pop && !push) count_d = count_q - CNT_ONE;
            case (state_q)
                IDLE: if (pop) state_d = RD;
                RD:   state_d = CALC;
                CALC: begin
                    new_w_d = calc_w;
                    sat_d   = calc_sat;
                    state_d = WR;
                end
                WR:   state_d = pop ? RD : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Event storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= push_dat;
    end

    // Control and event registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            cur_q    <= '0;
            new_w_q  <= 8'd0;
            sat_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            cur_q    <= cur_d;
            new_w_q  <= new_w_d;
            sat_q    <= sat_d;
        end
    end

`ifdef STDP_STATS_EN
    logic [15:0] ltp_cnt_q, ltp_cnt_d, ltd_cnt_q, ltd_cnt_d, sat_cnt_q, sat_cnt_d;

    assign ltp_cnt = ltp_cnt_q;
    assign ltd_cnt = ltd_cnt_q;
    assign sat_cnt = sat_cnt_q;

    // Statistics count completed write-backs; kill does not clear them.
    always_comb begin
        ltp_cnt_d = ltp_cnt_q;
        ltd_cnt_d = ltd_cnt_q;
        sat_cnt_d = sat_cnt_q;
        if (wr_fire) begin
            if (cur_q.ltp) ltp_cnt_d = ltp_cnt_q + 16'd1;
            else           ltd_cnt_d = ltd_cnt_q + 16'd1;
            if (sat_q)     sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ltp_cnt_q <= 16'd0;
            ltd_cnt_q <= 16'd0;
            sat_cnt_q <= 16'd0;
        end else begin
            ltp_cnt_q <= ltp_cnt_d;
            ltd_cnt_q <= ltd_cnt_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_stdp_weight_updater.sv
// Directed bench for stdp_weight_updater with a behavioural synapse table.
// Inputs change on negedge; outputs are sampled shortly after negedge.
// All expected weights are hand-computed constants.
module tb_stdp_weight_updater;

    logic        clk = 1'b0;
    logic        rst, kill, evt_valid, evt_ready, evt_type;
    logic [7:0]  evt_neuron;
    logic [3:0]  evt_dt;
    logic        syn_r_en, syn_w_en, busy;
    logic [7:0]  syn_neuron_num, syn_rd_weight, syn_wr_weight;
`ifdef STDP_STATS_EN
    logic [15:0] ltp_cnt, ltd_cnt, sat_cnt;
    int          sat0, ltp0;
`endif

    int n_vec  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int overlap = 0;

    logic [7:0] mem [256];
    int         wq_n [$];
    int         wq_w [$];
    int         wq_c [$];
    int         exp_w [6];

    stdp_weight_updater dut (
        .clk            (clk),
        .rst            (rst),
        .kill           (kill),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_neuron     (evt_neuron),
        .evt_type       (evt_type),
        .evt_dt         (evt_dt),
        .syn_r_en       (syn_r_en),
        .syn_w_en       (syn_w_en),
        .syn_neuron_num (syn_neuron_num),
        .syn_rd_weight  (syn_rd_weight),
        .syn_wr_weight  (syn_wr_weight),
        .busy           (busy)
`ifdef STDP_STATS_EN
        ,
        .ltp_cnt        (ltp_cnt),
        .ltd_cnt        (ltd_cnt),
        .sat_cnt        (sat_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Synapse table: read data is valid only in the cycle after syn_r_en.
    initial begin
        logic       pend;
        logic [7:0] pnum;
        syn_rd_weight = 8'hA5;
        forever begin
            @(negedge clk);
            #2;
            pend = syn_r_en;
            pnum = syn_neuron_num;
            @(posedge clk);
            #1;
            syn_rd_weight = pend ? mem[pnum] : 8'hA5;
        end
    end

    // Write-back monitor.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (syn_w_en) begin
                wq_n.push_back(int'(syn_neuron_num));
                wq_w.push_back(int'(syn_wr_weight));
                wq_c.push_back(cyc);
            end
            if (syn_r_en && syn_w_en) overlap++;
        end
    end

    task automatic clear_q();
        wq_n.delete();
        wq_w.delete();
        wq_c.delete();
    endtask

    task automatic offer(input logic [7:0] n, input logic t, input logic [3:0] dt);
        evt_valid  = 1'b1;
        evt_neuron = n;
        evt_type   = t;
        evt_dt     = dt;
    endtask

    task automatic wait_writes(input string tag, input int n, input int budget);
        for (int k = 0; k < budget && wq_n.size() < n; k++) @(negedge clk);
        #3;
        chk(tag, wq_n.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 30 && busy; k++) @(negedge clk);
        #1;
        chk(tag, busy, 0);
    endtask

    task automatic run_one(input string tag, input logic [7:0] n, input logic t,
                           input logic [3:0] dt, input int w);
        clear_q();
        @(negedge clk);
        offer(n, t, dt);
        @(negedge clk);
        evt_valid = 1'b0;
        wait_writes({tag, "_cnt"}, 1, 20);
        if (wq_n.size() > 0) begin
            chk({tag, "_num"}, wq_n[0], int'(n));
            chk({tag, "_w"}, wq_w[0], w);
        end
        wait_idle({tag, "_idle"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        mem[5] = 8'd100; mem[8'h33] = 8'd3; mem[8'h0A] = 8'd250; mem[8'h0B] = 8'd77;
        mem[1] = 8'd10; mem[2] = 8'd20; mem[3] = 8'd30; mem[4] = 8'd40; mem[6] = 8'd1;
        mem[8'h60] = 8'd50; mem[8'h61] = 8'd60;
        exp_w = '{14, 18, 34, 38, 104, 0};

        rst = 1'b0; kill = 1'b0; evt_valid = 1'b0;
        evt_neuron = 8'd0; evt_type = 1'b0; evt_dt = 4'd0;
        #1;
        chk("rst_r_en", syn_r_en, 0);
        chk("rst_w_en", syn_w_en, 0);
        chk("rst_ready", evt_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_num", syn_neuron_num, 0);
        chk("rst_wrw", syn_wr_weight, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // LTP cycle-accurate: push at t, r_en at t+2, w_en at t+4, 100 + (16>>1) = 108
`ifdef STDP_STATS_EN
        ltp0 = ltp_cnt;
`endif
        @(negedge clk);
        clear_q();
        offer(8'h05, 1'b1, 4'd1);
        @(negedge clk);
        evt_valid = 1'b0;
        #1 chk("ltp_r_en_t1", syn_r_en, 0);
        @(negedge clk);
        #1 chk("ltp_r_en_t2", syn_r_en, 1);
        chk("ltp_num_t2", syn_neuron_num, 5);
        @(negedge clk);
        #1 chk("ltp_w_en_t3", syn_w_en, 0);
        @(negedge clk);
        #1 chk("ltp_w_en_t4", syn_w_en, 1);
        chk("ltp_wr_t4", syn_wr_weight, 108);
        chk("ltp_num_t4", syn_neuron_num, 5);
        @(negedge clk);
        #1 chk("ltp_busy_t5", busy, 0);
`ifdef STDP_STATS_EN
        chk("ltp_cnt_inc", ltp_cnt, ltp0 + 1);
        sat0 = sat_cnt;
`endif

        // LTD saturation: 3 - 16 -> 0
        run_one("ltd_sat", 8'h33, 1'b0, 4'd0, 0);
`ifdef STDP_STATS_EN
        chk("sat_cnt_inc", sat_cnt, sat0 + 1);
`endif
        // LTP clamp 250+16 -> 255; dt=9 gives step 0 -> 77 rewritten
        run_one("ltp_clamp", 8'h0A, 1'b1, 4'd0, 255);
        run_one("ltp_dt9", 8'h0B, 1'b1, 4'd9, 77);

        // Burst of six: odd neurons LTP dt=2 (+4), even neurons LTD dt=3 (-2)
        clear_q();
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            offer(8'(i), 1'(i % 2), (i % 2 == 1) ? 4'd2 : 4'd3);
            #1;
            for (int k = 0; k < 20 && !evt_ready; k++) begin
                @(negedge clk);
                #1;
            end
        end
        @(negedge clk);
        evt_valid = 1'b0;
        #1 chk("burst_full_ready", evt_ready, 0);
        wait_writes("burst_cnt", 6, 60);
        for (int i = 0; i < 6 && i < wq_n.size(); i++) begin
            chk($sformatf("burst_num%0d", i), wq_n[i], i + 1);
            chk($sformatf("burst_w%0d", i), wq_w[i], exp_w[i]);
            if (i > 0) chk($sformatf("burst_gap%0d", i), wq_c[i] - wq_c[i-1], 3);
        end
        wait_idle("burst_idle");

        // kill in CALC with two events pending; a push during kill is dropped
        clear_q();
        @(negedge clk);
        offer(8'h40, 1'b1, 4'd0);
        @(negedge clk);
        offer(8'h41, 1'b1, 4'd0);
        @(negedge clk);
        offer(8'h42, 1'b1, 4'd0);
        #1 chk("kill_rd_phase", syn_r_en, 1);
        @(negedge clk);
        offer(8'h50, 1'b1, 4'd0);
        kill = 1'b1;
        #1 chk("kill_calc_w_en", syn_w_en, 0);
        @(negedge clk);
        kill = 1'b0;
        evt_valid = 1'b0;
        #1 chk("kill_busy_next", busy, 0);
        chk("kill_num_next", syn_neuron_num, 0);
        repeat (10) @(negedge clk);
        #3 chk("kill_no_writes", wq_n.size(), 0);
        chk("kill_still_idle", busy, 0);

        // kill landing on WR must suppress the write
        clear_q();
        @(negedge clk);
        offer(8'h60, 1'b1, 4'd0);
        @(negedge clk);
        evt_valid = 1'b0;
        repeat (3) @(negedge clk);
        kill = 1'b1;
        #1 chk("killwr_w_en", syn_w_en, 0);
        @(negedge clk);
        kill = 1'b0;
        #1 chk("killwr_busy", busy, 0);
        #3 chk("killwr_no_writes", wq_n.size(), 0);

        // asynchronous reset asserted during WR
        @(negedge clk);
        offer(8'h61, 1'b0, 4'd1);
        @(negedge clk);
        evt_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk("rstwr_pre_w_en", syn_w_en, 1);
        chk("rstwr_pre_w", syn_wr_weight, 52);
        rst = 1'b0;
        #1 chk("rstwr_w_en", syn_w_en, 0);
        chk("rstwr_ready", evt_ready, 1);
        chk("rstwr_busy", busy, 0);
        chk("rstwr_num", syn_neuron_num, 0);
        @(negedge clk);
        rst = 1'b1;

        chk("rd_wr_overlap", overlap, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
